collector_readout: RTL
======================

# collector_readout

Drains conditioned converter samples produced by the data collection path and ships them off-chip as a UART 8N1 byte stream. Samples arrive on a valid/ready handshake, are buffered in a small FIFO, and are serialized LSB-first on a single `tx` pin. This block is the reader/transmit end of the collector's sample stream and sits between the data collector output and a spare bidirectional pin.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range is 2..255.
- `FIFO_DEPTH`, default 8: sample buffer depth. Must be a power of 2, range 2..16.
- `PKT_LEN`, default 4: data bytes per packet. Used only when the checksum feature is compiled in. Range 1..255.

**Ports**
- `clk`, in, 1: single clock for all logic.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ena`, in, 1: transmit enable. Low blocks the start of new frames only.
- `sample_in`, in, 8: sample byte from the collector.
- `sample_valid`, in, 1: `sample_in` is valid this cycle.
- `sample_ready`, out, 1: FIFO can accept a sample. Equals `!full`.
- `tx`, out, 1: registered UART line. Idles high.
- `tx_busy`, out, 1: high in every state except IDLE.
- `fifo_count`, out, 5: current FIFO occupancy, 0..FIFO_DEPTH.
- `overflow`, out, 1: sticky flag. Set when `sample_valid` is high while `sample_ready` is low.

## Operation

**Reset values**
- `tx`=1, `tx_busy`=0, `sample_ready`=1, `fifo_count`=0, `overflow`=0.
- FSM is in IDLE.
- FIFO pointers and checksum state are cleared.

**Reset mid-frame**
- Aborts the frame immediately; `tx` returns high asynchronously.
- Buffered samples are discarded.

**FIFO**
- Push occurs on a clock edge when `sample_valid && sample_ready`.
- Pop occurs on the IDLE→START transition.
- Simultaneous push and pop leaves `fifo_count` unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
- When `overflow` is set, the offered sample is dropped and FIFO contents are untouched.
- `overflow` clears only on reset.

**FSM states:** IDLE, START, DATA, STOP.
- **IDLE → START:** when `ena && fifo_count != 0`. On that edge:
  - load the shift register from the FIFO head and pop;
  - drive `tx`=0;
  - clear the baud counter.
- **START → DATA:** after CLKS_PER_BIT cycles. Drive `tx`=shift[0] and set bit index = 0.
- **DATA:** each bit lasts CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit 7 completes → STOP with `tx`=1.
- **STOP → IDLE:** after CLKS_PER_BIT cycles.
- **ena low:** a frame already in progress runs to completion. Samples are still accepted while `ena` is low.

## Timing

- A frame occupies exactly 10×CLKS_PER_BIT cycles with `tx_busy` high.
- The start bit begins on the edge after `ena && fifo_count != 0` is first sampled in IDLE.
- Back-to-back frames are separated by exactly 1 IDLE cycle (`tx`=1, `tx_busy`=0).
- `sample_ready` updates the cycle after a push/pop changes the full status. There is no combinational path from `sample_valid` to `sample_ready`.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide. The bit index is 3 bits.

## Configuration

**`READOUT_CHECKSUM_EN`**

Defined:
- A sent-byte counter and an 8-bit mod-256 running sum are maintained.
- After the PKT_LEN-th data frame, the next frame carries the checksum byte (sum of those PKT_LEN bytes, overflow discarded) instead of a FIFO byte.
- The checksum frame:
  - does not pop the FIFO;
  - starts when `ena` is high, even if the FIFO is empty;
  - obeys the same 1-cycle IDLE gap as a data frame.
- The counter and sum clear after the checksum frame is sent.

Undefined:
- Only raw data bytes are sent.
- The counter and sum logic is absent.

## Test plan

Test parameters: CLKS_PER_BIT=4, FIFO_DEPTH=8, PKT_LEN=4.

1. **Reset state:** assert `rst_n`=0 mid-frame → `tx`=1 immediately; after release, `fifo_count`=0, `tx_busy`=0, `overflow`=0.
2. **Single byte:** push 0x5A with `ena`=1 → `tx` is 0 for 4 cycles, then bits 0,1,0,1,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; `tx_busy` is high for 40 cycles.
3. **Full and overflow:** `ena`=0, push 9 samples 0x01..0x09 → `fifo_count`=8, `sample_ready`=0 after the 8th push, and `overflow`=1 on the 9th; set `ena`=1 → 0x01..0x08 are transmitted in order with 1-cycle gaps (frames start 41 cycles apart).
4. **Simultaneous push/pop:** push on the same cycle as an IDLE→START pop with `fifo_count`=3 → `fifo_count` stays 3.
5. **ena gating:** drop `ena` during bit 3 → the frame completes and no new START occurs while `ena`=0.
6. **Checksum (`READOUT_CHECKSUM_EN`):** send 0x10, 0x20, 0x30, 0xF0 → a fifth frame carries 0x50 and `fifo_count` is unchanged by that frame; with the macro undefined, only the 4 data frames appear.

Source files
------------

// File: rtl/collector_readout_if.sv
// collector_readout_if: sample handshake, transmit enable and status bundle for collector_readout.
// Latency: none, wires only.
// Backpressure: sample_ready low means the offered sample is dropped and overflow is raised.
// Members:
//   ena                     transmit enable (new frames only)
//   sample_in/sample_valid  sample byte offered by the collector
//   sample_ready            buffer has room (registered, equals !full)
//   tx                      registered UART 8N1 line, idles high
//   tx_busy                 a frame is in progress
//   fifo_count              buffer occupancy
//   overflow                sticky drop flag
// master = collector/host side, slave = collector_readout.
interface collector_readout_if;
  logic       ena;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       tx;
  logic       tx_busy;
  logic [4:0] fifo_count;
  logic       overflow;

  modport master (
    output ena, sample_in, sample_valid,
    input  sample_ready, tx, tx_busy, fifo_count, overflow
  );

  modport slave (
    input  ena, sample_in, sample_valid,
    output sample_ready, tx, tx_busy, fifo_count, overflow
  );
endinterface

// File: rtl/collector_readout.sv
// collector_readout: buffers collector samples and serializes them LSB-first as UART 8N1 on tx.
// Latency: start bit begins on the edge after ena && fifo_count != 0 is sampled in IDLE; frame = 10*CLKS_PER_BIT.
// Backpressure: sample_ready = !full (registered); samples offered while full are dropped and set sticky overflow.
// Ports: clk, rst_n (async active-low), bus (collector_readout_if.slave: ena, sample_in/valid/ready,
//   tx, tx_busy, fifo_count, overflow).
// Optional feature: define READOUT_CHECKSUM_EN to append a mod-256 checksum frame after every PKT_LEN data frames.

// Generic single-clock FIFO; count is the occupancy, pop_dat shows the head word.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module collector_readout #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int PKT_LEN      = 4
) (
  input logic                clk,
  input logic                rst_n,
  collector_readout_if.slave bus
);
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255) begin : g_bad_clks_per_bit
    $error("collector_readout: CLKS_PER_BIT must be 2..255");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("collector_readout: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (PKT_LEN < 1 || PKT_LEN > 255) begin : g_bad_pkt_len
    $error("collector_readout: PKT_LEN must be 1..255");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_q;
  logic          overflow_q;

  logic [7:0]    head_dat;
  logic [FW-1:0] fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          start_data;
  logic          start_cks;
  logic          start_frame;
  logic [7:0]    frame_byte;
  logic          baud_done;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (bus.sample_valid),
    .push_dat (bus.sample_in),
    .pop      (start_data),
    .pop_dat  (head_dat),
    .count    (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign baud_done = (baud_cnt == BAUD_LAST);

`ifdef READOUT_CHECKSUM_EN
  logic [7:0] byte_cnt;
  logic [7:0] sum;
  logic       cks_frame;
  logic       cks_due;

  // Once PKT_LEN data frames have gone out, the checksum frame takes
  // priority and is sent even with an empty FIFO.
  assign cks_due    = (byte_cnt == 8'(PKT_LEN));
  assign start_cks  = (state == S_IDLE) && bus.ena && cks_due;
  assign start_data = (state == S_IDLE) && bus.ena && !fifo_empty && !cks_due;
  assign frame_byte = start_cks ? sum : head_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      sum       <= '0;
      cks_frame <= 1'b0;
    end else begin
      if (start_data) begin
        byte_cnt <= byte_cnt + 8'd1;
        sum      <= sum + head_dat;
      end
      if (start_cks) cks_frame <= 1'b1;
      // Clear only once the checksum frame has fully left the pin.
      if (cks_frame && state == S_STOP && baud_done) begin
        byte_cnt  <= '0;
        sum       <= '0;
        cks_frame <= 1'b0;
      end
    end
  end
`else
  assign start_cks  = 1'b0;
  assign start_data = (state == S_IDLE) && bus.ena && !fifo_empty;
  assign frame_byte = head_dat;
`endif

  assign start_frame = start_data || start_cks;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_frame) begin
            state    <= S_START;
            shift    <= frame_byte;
            tx_q     <= 1'b0;
            baud_cnt <= '0;
          end
        end
        S_START: begin
          if (baud_done) begin
            state    <= S_DATA;
            tx_q     <= shift[0];
            bit_idx  <= '0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx_q  <= 1'b1;
            end else begin
              // Next bit on the line is the one that becomes shift[0].
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (baud_done) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             overflow_q <= 1'b0;
    else if (bus.sample_valid && fifo_full) overflow_q <= 1'b1;
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = (state != S_IDLE);
  assign bus.sample_ready = !fifo_full;
  assign bus.fifo_count   = 5'(fifo_cnt);
  assign bus.overflow     = overflow_q;
endmodule
